// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and digit-select helper for the
// 7-segment scan driver. Segment patterns are active-high here (1 = lit).
// The pins are active-low.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DISP_W     = 42;

  // Bit positions of each segment inside a 7-bit pattern
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Idle pin levels: every segment and every anode released
  localparam logic [SEG_W-1:0]      SEG_BLANK_N = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF_N    = 6'h3F;

  // Slot phase. BLANK keeps all anodes off to stop ghosting between digits.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Pick digit i out of the 42-bit display word. Digit 0 is rightmost.
  function automatic logic [SEG_W-1:0] digit_sel(input logic [DISP_W-1:0] word,
                                                 input logic [2:0]        idx);
    logic [SEG_W-1:0] pat;
    pat = word[6:0];
    case (idx)
      3'd0:    pat = word[6:0];
      3'd1:    pat = word[13:7];
      3'd2:    pat = word[20:14];
      3'd3:    pat = word[27:21];
      3'd4:    pat = word[34:28];
      3'd5:    pat = word[41:35];
      default: pat = word[6:0];
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running modulo-DIV counter. It counts 0..DIV-1 and then wraps.
// slot_end_o is high during the wrap cycle (count == DIV-1).
// count_next_o is the value the counter takes on the next edge. The
// consumers use it to line up their own state changes with the counter.
module scan_prescaler #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] count_o,
  output logic             slot_end_o,
  output logic [CNT_W-1:0] count_next_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero at the last value
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o      = cnt_q;
  assign slot_end_o   = (cnt_q == LAST);
  assign count_next_o = cnt_d;

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scan driver.
// The display word is captured into a shadow register once per frame, so a
// frame never mixes old and new digits. Each digit slot lasts SCAN_DIV
// cycles. The first BLANK_CYCLES cycles of a slot keep every anode off.
// All pins are registered, so they lag the counter state by one cycle.
// Optional build macro SEG_DIM_EN adds a brightness input. That input
// gates the anode with a 3-bit PWM.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DISP_W-1:0]     display,
  input  logic                  en,
`ifdef SEG_DIM_EN
  input  logic [2:0]            brightness,
`endif
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick,
  output logic                  dbg_state_o
);

  localparam int unsigned      CNT_W   = 16;
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             slot_end;

  scan_prescaler #(
    .DIV   (SCAN_DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_o      (cnt),
    .slot_end_o   (slot_end),
    .count_next_o (cnt_next)
  );

  logic [2:0]            idx_q,    idx_d;
  logic [DISP_W-1:0]     shadow_q, shadow_d;
  logic                  first_q;
  logic                  ft_q,     ft_d;
  scan_state_e           state_q,  state_d;
  logic [SEG_W-1:0]      seg_q,    seg_d;
  logic [NUM_DIGITS-1:0] an_q,     an_d;
  logic                  frame_wrap;
  logic                  pwm_on;

  // The frame ends when the last digit's slot ends
  assign frame_wrap = slot_end && (idx_q == LAST_IDX);

`ifdef SEG_DIM_EN
  logic [2:0] pwm_q;

  // Free-running PWM phase. Its period is 8 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 3'd0;
    else        pwm_q <= pwm_q + 3'd1;
  end

  // Anode on for brightness+1 of every 8 cycles
  assign pwm_on = ({1'b0, pwm_q} < ({1'b0, brightness} + 4'd1));
`else
  assign pwm_on = 1'b1;
`endif

  // Digit index, shadow capture and frame pulse
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ft_d     = frame_wrap;
    if (slot_end) begin
      if (idx_q == LAST_IDX) idx_d = 3'd0;
      else                   idx_d = idx_q + 3'd1;
    end
    if (first_q || frame_wrap) shadow_d = display;
  end

  // Scan bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 3'd0;
      shadow_q <= '0;
      first_q  <= 1'b1;
      ft_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      first_q  <= 1'b0;
      ft_q     <= ft_d;
    end
  end

  // Slot-phase FSM next state. It tracks whether the prescaler is past the blank window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK: if (cnt_next >= BLANK_C) state_d = DRIVE;
      DRIVE: if (slot_end) state_d = (BLANK_C == '0) ? DRIVE : BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Slot-phase FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BLANK;
    else        state_q <= state_d;
  end

  // Pin values for the next cycle. Pins stay blank unless enabled and in DRIVE.
  always_comb begin
    seg_d = SEG_BLANK_N;
    an_d  = AN_OFF_N;
    if (en && (state_q == DRIVE)) begin
      seg_d = ~digit_sel(shadow_q, idx_q);
      if (pwm_on) an_d = ~(6'b000001 << idx_q);
    end
  end

  // Output pin registers. Reset releases the pins without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK_N;
      an_q  <= AN_OFF_N;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_n       = seg_q;
  assign an_n        = an_q;
  assign frame_tick  = ft_q;
  assign dbg_state_o = state_q;

endmodule
